ac_op_sequencer: RTL and testbench

//  Sequences operations on the 8-bit accumulator, whose LD/CLR/COM/CIR/CIL inputs act on rising edges.

---
 rtl/ac_seq_pkg.sv | 44 ++++
 rtl/ac_op_sequencer_pulse_timer.sv | 26 ++
 rtl/ac_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ac_op_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ac_seq_pkg.sv
// Shared opcodes, FSM encoding and pulse-line indexing for the accumulator op sequencer.
package ac_seq_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LD    = 3'd1;
    localparam logic [2:0] OP_CLR   = 3'd2;
    localparam logic [2:0] OP_COM   = 3'd3;
    localparam logic [2:0] OP_CIR   = 3'd4;
    localparam logic [2:0] OP_CIL   = 3'd5;
    localparam logic [2:0] OP_SWAPN = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    // A nibble swap is four single-bit left rotations.
    localparam int unsigned SWAPN_REPEAT = 4;

    localparam int unsigned NUM_PULSES = 5;
    localparam int unsigned PL_LD  = 0;
    localparam int unsigned PL_CLR = 1;
    localparam int unsigned PL_COM = 2;
    localparam int unsigned PL_CIR = 3;
    localparam int unsigned PL_CIL = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [NUM_PULSES-1:0] op_pulse_sel(input logic [2:0] op);
        logic [NUM_PULSES-1:0] sel;
        sel = '0;
        case (op)
            OP_LD:             sel[PL_LD]  = 1'b1;
            OP_CLR:            sel[PL_CLR] = 1'b1;
            OP_COM:            sel[PL_COM] = 1'b1;
            OP_CIR:            sel[PL_CIR] = 1'b1;
            OP_CIL, OP_SWAPN:  sel[PL_CIL] = 1'b1;
            default:           sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ac_op_sequencer_pulse_timer.sv
// Loadable down-counter timing the HIGH and LOW phases; expired when it reaches zero.
module pulse_timer #(
    parameter int unsigned W = 1
) (
    input  logic         CLK,
    input  logic         CLR_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge CLR_clear) begin
        if (CLR_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/ac_op_sequencer.sv
// Expands one accepted opcode into registered one-hot accumulator pulses separated by low gaps.
module ac_op_sequencer
    import ac_seq_pkg::*;
#(
    parameter int unsigned PULSE_W = 1,
    parameter int unsigned GAP_W   = 1,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             CLK,
    input  logic             CLR_clear,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [CNT_W-1:0] op_count,
    input  logic [7:0]       load_data,
    input  logic [7:0]       ac_q,
    output logic [7:0]       ac_data,
    output logic             ac_ld,
    output logic             ac_clr,
    output logic             ac_com,
    output logic             ac_cir,
    output logic             ac_cil,
    output logic             op_done,
    output logic [7:0]       result,
    output logic             err_illegal,
    output logic             busy
);

    localparam int unsigned MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int unsigned TW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    // Remaining counter must also hold SWAPN_REPEAT.
    localparam int unsigned RW    = (CNT_W > 3) ? CNT_W : 3;
    localparam logic [TW-1:0] HIGH_LOAD = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_W - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_op;
    logic [7:0]            r_ac_data;
    logic [RW-1:0]         r_rem;
    logic [RW-1:0]         w_rem_next;
    logic [RW-1:0]         w_init_rem;
    logic [NUM_PULSES-1:0] r_pulse;
    logic [NUM_PULSES-1:0] w_pulse_next;
    logic                  r_op_done;
    logic                  r_err;
    logic                  w_err_next;
    logic [7:0]            r_result;
    logic                  w_accept;
    logic                  w_tmr_load;
    logic [TW-1:0]         w_tmr_value;
    logic                  w_tmr_expired;

    pulse_timer #(
        .W(TW)
    ) u_timer (
        .CLK       (CLK),
        .CLR_clear (CLR_clear),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_tmr_expired)
    );

    always_comb begin
        w_init_rem = RW'(1);
        if (op_code == OP_CIR || op_code == OP_CIL) begin
            w_init_rem = (op_count == '0) ? RW'(1) : RW'(op_count);
        end else if (op_code == OP_SWAPN) begin
            w_init_rem = RW'(SWAPN_REPEAT);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pulse_next = '0;
        w_rem_next   = r_rem;
        w_accept     = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_value  = '0;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    w_accept   = 1'b1;
                    w_rem_next = w_init_rem;
                    if (op_code == OP_NOP || op_code == OP_ILL) begin
                        w_state_next = ST_DONE;
                        w_err_next   = (op_code == OP_ILL);
                    end else begin
                        w_state_next = ST_HIGH;
                        w_pulse_next = op_pulse_sel(op_code);
                        w_tmr_load   = 1'b1;
                        w_tmr_value  = HIGH_LOAD;
                    end
                end
            end
            ST_HIGH: begin
                if (w_tmr_expired) begin
                    w_state_next = ST_LOW;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = GAP_LOAD;
                end else begin
                    w_pulse_next = op_pulse_sel(r_op);
                end
            end
            ST_LOW: begin
                if (w_tmr_expired) begin
                    w_rem_next = r_rem - RW'(1);
                    if (r_rem != RW'(1)) begin
                        w_state_next = ST_HIGH;
                        w_pulse_next = op_pulse_sel(r_op);
                        w_tmr_load   = 1'b1;
                        w_tmr_value  = HIGH_LOAD;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Pulse lines are registered from the next-state decode so they never glitch.
    always_ff @(posedge CLK or posedge CLR_clear) begin
        if (CLR_clear) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_NOP;
            r_ac_data <= '0;
            r_rem     <= '0;
            r_pulse   <= '0;
            r_op_done <= 1'b0;
            r_err     <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_rem     <= w_rem_next;
            r_pulse   <= w_pulse_next;
            r_op_done <= (w_state_next == ST_DONE);
            r_err     <= w_err_next;
            if (w_accept) begin
                r_op      <= op_code;
                r_ac_data <= load_data;
            end
            if (r_state == ST_DONE) begin
                r_result <= ac_q;
            end
        end
    end

    assign op_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign ac_data     = r_ac_data;
    assign ac_ld       = r_pulse[PL_LD];
    assign ac_clr      = r_pulse[PL_CLR];
    assign ac_com      = r_pulse[PL_COM];
    assign ac_cir      = r_pulse[PL_CIR];
    assign ac_cil      = r_pulse[PL_CIL];
    assign op_done     = r_op_done;
    assign err_illegal = r_err;
    assign result      = r_result;

endmodule

// File: tb/tb_ac_op_sequencer.sv
// Drives directed and random opcodes into the sequencer with an edge-triggered accumulator model attached.
module tb_ac_op_sequencer;

    logic       CLK;
    logic       CLR_clear;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [2:0] op_count;
    logic [7:0] load_data;
    logic [7:0] ac_q;
    logic [7:0] ac_data;
    logic       ac_ld, ac_clr, ac_com, ac_cir, ac_cil;
    logic       op_done;
    logic [7:0] result;
    logic       err_illegal;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    ac_op_sequencer dut (
        .CLK         (CLK),
        .CLR_clear   (CLR_clear),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_count    (op_count),
        .load_data   (load_data),
        .ac_q        (ac_q),
        .ac_data     (ac_data),
        .ac_ld       (ac_ld),
        .ac_clr      (ac_clr),
        .ac_com      (ac_com),
        .ac_cir      (ac_cir),
        .ac_cil      (ac_cil),
        .op_done     (op_done),
        .result      (result),
        .err_illegal (err_illegal),
        .busy        (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accumulator model: acts on rising edges of its control lines, untouched by the sequencer reset.
    logic [7:0] ac = 8'h98;
    int cnt_ld, cnt_clr, cnt_com, cnt_cir, cnt_cil;
    assign ac_q = ac;

    always @(posedge ac_ld)  begin cnt_ld++;  #1; ac = ac_data; end
    always @(posedge ac_clr) begin cnt_clr++; #1; ac = 8'h00; end
    always @(posedge ac_com) begin cnt_com++; #1; ac = ~ac; end
    always @(posedge ac_cir) begin cnt_cir++; #1; ac = {ac[0], ac[7:1]}; end
    always @(posedge ac_cil) begin cnt_cil++; #1; ac = {ac[6:0], ac[7]}; end

    // Every-cycle properties: one-hot-or-zero pulses, a low cycle between pulses, stable operand.
    logic       prev_any;
    logic       prev_busy;
    logic [7:0] prev_data;
    always @(negedge CLK) begin
        if (CLR_clear) begin
            prev_any  = 1'b0;
            prev_busy = 1'b0;
            prev_data = 8'h00;
        end else begin
            check("pulse_onehot0", 32'($onehot0({ac_ld, ac_clr, ac_com, ac_cir, ac_cil})), 32'd1);
            if (prev_any)
                check("pulse_gap", 32'({ac_ld, ac_clr, ac_com, ac_cir, ac_cil}), 32'd0);
            if (busy && prev_busy)
                check("ac_data_stable", 32'(ac_data), 32'(prev_data));
            prev_any  = |{ac_ld, ac_clr, ac_com, ac_cir, ac_cil};
            prev_busy = busy;
            prev_data = ac_data;
        end
    end

    logic [7:0] model_ac = 8'h98;

    function automatic int reps(input logic [2:0] code, input logic [2:0] cnt);
        case (code)
            3'd1, 3'd2, 3'd3: return 1;
            3'd4, 3'd5:       return (cnt == 3'd0) ? 1 : int'(cnt);
            3'd6:             return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        int k;
        int v;
        k = n % 8;
        v = int'(x);
        v = (v << k) | (v >> (8 - k));
        return v[7:0];
    endfunction

    function automatic logic [7:0] ref_op(input logic [2:0] code, input logic [2:0] cnt,
                                          input logic [7:0] data, input logic [7:0] acc);
        case (code)
            3'd1:    return data;
            3'd2:    return 8'h00;
            3'd3:    return ~acc;
            3'd4:    return rotl(acc, 8 - (reps(code, cnt) % 8));
            3'd5:    return rotl(acc, reps(code, cnt));
            3'd6:    return {acc[3:0], acc[7:4]};
            default: return acc;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] code, input logic [2:0] cnt, input logic [7:0] data,
                          input string tag);
        int         n;
        int         exp_lat;
        int         lat;
        bit         seen;
        logic [7:0] exp_res;
        logic [19:0] exp_cnt;
        n       = reps(code, cnt);
        exp_lat = (n == 0) ? 1 : 1 + 2 * n;
        exp_res = ref_op(code, cnt, data, model_ac);
        exp_cnt = {4'(code == 3'd1 ? 1 : 0), 4'(code == 3'd2 ? 1 : 0), 4'(code == 3'd3 ? 1 : 0),
                   4'(code == 3'd4 ? n : 0), 4'(code == 3'd5 || code == 3'd6 ? n : 0)};
        check({tag, " op_ready_before"}, 32'(op_ready), 32'd1);
        cnt_ld = 0; cnt_clr = 0; cnt_com = 0; cnt_cir = 0; cnt_cil = 0;
        op_valid  = 1'b1;
        op_code   = code;
        op_count  = cnt;
        load_data = data;
        @(posedge CLK);
        #1;
        op_code   = 3'($urandom);
        op_count  = 3'($urandom);
        load_data = 8'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            op_valid = 1'($urandom_range(0, 1));
            @(negedge CLK);
            lat++;
            if (op_done) seen = 1'b1;
        end
        op_valid = 1'b0;
        check({tag, " done_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err_with_done"}, 32'(err_illegal), 32'(code == 3'd7));
        check({tag, " pulse_counts"},
              32'({4'(cnt_ld), 4'(cnt_clr), 4'(cnt_com), 4'(cnt_cir), 4'(cnt_cil)}), 32'(exp_cnt));
        @(negedge CLK);
        check({tag, " done_one_cycle"}, 32'(op_done), 32'd0);
        check({tag, " err_cleared"}, 32'(err_illegal), 32'd0);
        check({tag, " op_ready_after"}, 32'(op_ready), 32'd1);
        check({tag, " result"}, 32'(result), 32'(exp_res));
        $display("op %s code=%0d cnt=%0d data=%02h latency=%0d result=%02h", tag, code, cnt, data, lat, result);
        model_ac = exp_res;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CLR_clear = 1'b1;
        op_valid  = 1'b0;
        op_code   = 3'd0;
        op_count  = 3'd0;
        load_data = 8'h00;
        repeat (2) @(negedge CLK);
        check("reset op_ready", 32'(op_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset op_done", 32'(op_done), 32'd0);
        check("reset err", 32'(err_illegal), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset ac_data", 32'(ac_data), 32'd0);
        check("reset pulses", 32'({ac_ld, ac_clr, ac_com, ac_cir, ac_cil}), 32'd0);
        CLR_clear = 1'b0;
        @(negedge CLK);

        run_op(3'd1, 3'd0, 8'h5A, "ld_5a");
        run_op(3'd2, 3'd0, 8'h11, "clr");
        run_op(3'd3, 3'd0, 8'h22, "com");
        run_op(3'd1, 3'd0, 8'h81, "ld_81");
        run_op(3'd4, 3'd3, 8'h00, "cir_x3");
        run_op(3'd1, 3'd0, 8'h81, "ld_81b");
        run_op(3'd4, 3'd0, 8'h00, "cir_x0");
        run_op(3'd1, 3'd0, 8'h3C, "ld_3c");
        run_op(3'd6, 3'd0, 8'h00, "swapn");
        run_op(3'd7, 3'd2, 8'h77, "illegal");
        run_op(3'd0, 3'd5, 8'h66, "nop");

        for (int i = 0; i < 25; i++) begin
            run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom), "rand");
        end

        // Reset in the middle of a rotation, while the first pulse is high.
        cnt_cil   = 0;
        op_valid  = 1'b1;
        op_code   = 3'd5;
        op_count  = 3'd5;
        load_data = 8'h00;
        @(posedge CLK);
        #1;
        op_valid = 1'b0;
        check("midrot cil_high", 32'(ac_cil), 32'd1);
        #2;
        CLR_clear = 1'b1;
        #1;
        check("midrot cil_dropped", 32'(ac_cil), 32'd0);
        check("midrot op_ready", 32'(op_ready), 32'd1);
        check("midrot result", 32'(result), 32'd0);
        check("midrot op_done", 32'(op_done), 32'd0);
        check("midrot cil_count", 32'(cnt_cil), 32'd1);
        $display("op midrot_reset cil_pulses=%0d ac=%02h", cnt_cil, ac_q);
        model_ac = rotl(model_ac, cnt_cil);
        @(negedge CLK);
        CLR_clear = 1'b0;
        @(negedge CLK);
        run_op(3'd1, 3'd0, 8'hA5, "ld_after_reset");
        run_op(3'd5, 3'd2, 8'h00, "cil_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
